// File: rtl/draw_sched.sv
// Draw job scheduler: sequences an optional screen fill and then a Reuleaux draw.
// It latches the job parameters and muxes the active engine's pixel stream onto the
// VGA port, with clipping to the 160x120 window. It also keeps busy and clip counters.
module draw_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        done,
    input  logic        clear_en,
    input  logic [2:0]  colour,
    input  logic [7:0]  centre_x,
    input  logic [6:0]  centre_y,
    input  logic [7:0]  diameter,
    output logic [2:0]  r_colour,
    output logic [7:0]  r_centre_x,
    output logic [6:0]  r_centre_y,
    output logic [7:0]  r_diameter,
    output logic        fill_start,
    input  logic        fill_done,
    input  logic [7:0]  fill_x,
    input  logic [6:0]  fill_y,
    input  logic [2:0]  fill_colour,
    input  logic        fill_plot,
    output logic        reul_start,
    input  logic        reul_done,
    input  logic [7:0]  reul_x,
    input  logic [6:0]  reul_y,
    input  logic [2:0]  reul_colour,
    input  logic        reul_plot,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        vga_plot,
    output logic [15:0] busy_cycles,
    output logic [15:0] clip_count
);

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StFillAck,
        StDraw,
        StDrawAck,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic        accept;
    logic        sel_plot;
    logic        clip;
    logic [15:0] busy_q;
    logic [15:0] clip_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and Moore handshake outputs; one state per edge even if done is
    // already high on entry.
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        fill_start = 1'b0;
        reul_start = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = clear_en ? StFill : StDraw;
                end
            end
            StFill: begin
                fill_start = 1'b1;
                if (fill_done) state_d = StFillAck;
            end
            StFillAck: begin
                if (!fill_done) state_d = StDraw;
            end
            StDraw: begin
                reul_start = 1'b1;
                if (reul_done) state_d = StDrawAck;
            end
            StDrawAck: begin
                if (!reul_done) state_d = StDone;
            end
            StDone: begin
                done = 1'b1;
                if (!start) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Job parameters are captured only when a start is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_colour   <= '0;
            r_centre_x <= '0;
            r_centre_y <= '0;
            r_diameter <= '0;
        end else if (accept) begin
            r_colour   <= colour;
            r_centre_x <= centre_x;
            r_centre_y <= centre_y;
            r_diameter <= diameter;
        end
    end

    // Zero-latency pixel mux; off-screen plots are suppressed and flagged for counting.
    always_comb begin
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        sel_plot   = 1'b0;
        if (state_q == StFill) begin
            vga_x      = fill_x;
            vga_y      = fill_y;
            vga_colour = fill_colour;
            sel_plot   = fill_plot;
        end else if (state_q == StDraw) begin
            vga_x      = reul_x;
            vga_y      = reul_y;
            vga_colour = reul_colour;
            sel_plot   = reul_plot;
        end
        clip     = sel_plot && ((vga_x > 8'd159) || (vga_y > 7'd119));
        vga_plot = sel_plot && !clip;
    end

    // Saturating job counters; cleared when a job is accepted, frozen in IDLE and DONE.
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            busy_q <= '0;
            clip_q <= '0;
        end else begin
            if (state_q != StIdle && state_q != StDone && busy_q != 16'hFFFF) begin
                busy_q <= busy_q + 16'd1;
            end
            if (clip && clip_q != 16'hFFFF) begin
                clip_q <= clip_q + 16'd1;
            end
        end
    end

    assign busy_cycles = busy_q;
    assign clip_count  = clip_q;

endmodule

// File: tb/tb_draw_sched.sv
// Directed bench for draw_sched: the bench plays both engines by hand.
module tb_draw_sched;

    logic        clk = 1'b0;
    logic        rst, start, done, clear_en;
    logic [2:0]  colour, r_colour, fill_colour, reul_colour, vga_colour;
    logic [7:0]  centre_x, diameter, r_centre_x, r_diameter, fill_x, reul_x, vga_x;
    logic [6:0]  centre_y, r_centre_y, fill_y, reul_y, vga_y;
    logic        fill_start, fill_done, fill_plot, reul_start, reul_done, reul_plot, vga_plot;
    logic [15:0] busy_cycles, clip_count;

    int n_checks = 0;
    int n_fail   = 0;

    draw_sched dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .done        (done),
        .clear_en    (clear_en),
        .colour      (colour),
        .centre_x    (centre_x),
        .centre_y    (centre_y),
        .diameter    (diameter),
        .r_colour    (r_colour),
        .r_centre_x  (r_centre_x),
        .r_centre_y  (r_centre_y),
        .r_diameter  (r_diameter),
        .fill_start  (fill_start),
        .fill_done   (fill_done),
        .fill_x      (fill_x),
        .fill_y      (fill_y),
        .fill_colour (fill_colour),
        .fill_plot   (fill_plot),
        .reul_start  (reul_start),
        .reul_done   (reul_done),
        .reul_x      (reul_x),
        .reul_y      (reul_y),
        .reul_colour (reul_colour),
        .reul_plot   (reul_plot),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .vga_plot    (vga_plot),
        .busy_cycles (busy_cycles),
        .clip_count  (clip_count)
    );

    always #5 clk = ~clk;

    // Count one comparison and report it if it differs.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; clear_en = 1'b0;
        colour = '0; centre_x = '0; centre_y = '0; diameter = '0;
        fill_done = 1'b0; fill_x = '0; fill_y = '0; fill_colour = '0; fill_plot = 1'b0;
        reul_done = 1'b0; reul_x = '0; reul_y = '0; reul_colour = '0; reul_plot = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_eq("rst_done", done, 0);
        check_eq("rst_fill_start", fill_start, 0);
        check_eq("rst_reul_start", reul_start, 0);
        check_eq("rst_r_centre_x", r_centre_x, 0);
        check_eq("rst_busy", busy_cycles, 0);
        check_eq("rst_clip", clip_count, 0);
        check_eq("rst_vga_plot", vga_plot, 0);

        // Job 1: clear then draw, fill engine answers after 10 cycles.
        clear_en = 1'b1; colour = 3'b010; centre_x = 8'd80; centre_y = 7'd60;
        diameter = 8'd40; start = 1'b1;
        tick();
        check_eq("j1_fill_start", fill_start, 1);
        check_eq("j1_reul_start_in_fill", reul_start, 0);
        check_eq("j1_r_colour", r_colour, 2);
        check_eq("j1_r_centre_x", r_centre_x, 80);
        check_eq("j1_r_centre_y", r_centre_y, 60);
        check_eq("j1_r_diameter", r_diameter, 40);
        fill_x = 8'd159; fill_y = 7'd119; fill_colour = 3'd0; fill_plot = 1'b1;
        #1;
        check_eq("fill_corner_plot", vga_plot, 1);
        check_eq("fill_corner_x", vga_x, 159);
        check_eq("fill_corner_y", vga_y, 119);
        for (int i = 0; i < 10; i++) begin
            check_eq("fill_start_held", fill_start, 1);
            if (i == 9) fill_done = 1'b1;
            tick();
        end
        check_eq("fill_ack_fill_start", fill_start, 0);
        check_eq("fill_ack_vga_plot", vga_plot, 0);
        check_eq("fill_ack_vga_x", vga_x, 0);
        check_eq("busy_after_fill", busy_cycles, 10);
        check_eq("clip_after_fill", clip_count, 0);
        fill_plot = 1'b0; fill_done = 1'b0;
        tick();
        check_eq("draw_reul_start", reul_start, 1);
        check_eq("draw_fill_start", fill_start, 0);

        // Off-screen x for 5 cycles.
        reul_x = 8'd190; reul_y = 7'd50; reul_colour = 3'd7; reul_plot = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("clip_x_vga_plot", vga_plot, 0);
            tick();
        end
        check_eq("clip_x_count", clip_count, 5);
        check_eq("busy_mid_draw", busy_cycles, 16);

        // Off-screen y; job parameters changed mid-job are ignored.
        centre_x = 8'd60;
        reul_x = 8'd10; reul_y = 7'd127;
        #1;
        check_eq("clip_y_vga_plot", vga_plot, 0);
        tick();
        check_eq("clip_y_count", clip_count, 6);
        reul_x = 8'd20; reul_y = 7'd30;
        #1;
        check_eq("draw_onscreen_plot", vga_plot, 1);
        check_eq("draw_onscreen_x", vga_x, 20);
        check_eq("draw_onscreen_colour", vga_colour, 7);
        reul_plot = 1'b0;
        reul_done = 1'b1;
        tick();
        check_eq("draw_ack_reul_start", reul_start, 0);
        check_eq("r_centre_x_held", r_centre_x, 80);
        reul_done = 1'b0;
        tick();
        check_eq("j1_done", done, 1);
        check_eq("j1_busy_total", busy_cycles, 19);
        check_eq("j1_clip_total", clip_count, 6);
        tick();
        check_eq("done_held_by_start", done, 1);
        check_eq("busy_frozen_in_done", busy_cycles, 19);
        start = 1'b0;
        tick();
        check_eq("back_to_idle_done", done, 0);

        // Job 2: no clear; start dropped mid-job then reset in DRAW.
        clear_en = 1'b0; colour = 3'd1; start = 1'b1;
        tick();
        check_eq("j2_reul_start", reul_start, 1);
        check_eq("j2_no_fill_start", fill_start, 0);
        check_eq("j2_busy_cleared", busy_cycles, 0);
        check_eq("j2_clip_cleared", clip_count, 0);
        start = 1'b0;
        tick();
        check_eq("j2_start_drop_ignored", reul_start, 1);
        check_eq("j2_busy_one", busy_cycles, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rst_mid_reul_start", reul_start, 0);
        check_eq("rst_mid_done", done, 0);
        check_eq("rst_mid_busy", busy_cycles, 0);
        check_eq("rst_mid_r_colour", r_colour, 0);

        // Job 3: new start accepted after reset.
        colour = 3'd5; centre_x = 8'd10; centre_y = 7'd20; diameter = 8'd30; start = 1'b1;
        tick();
        check_eq("j3_reul_start", reul_start, 1);
        check_eq("j3_r_colour", r_colour, 5);
        check_eq("j3_r_diameter", r_diameter, 30);
        reul_done = 1'b1;
        tick();
        reul_done = 1'b0;
        tick();
        check_eq("j3_done", done, 1);
        check_eq("j3_busy", busy_cycles, 2);
        start = 1'b0;
        tick();
        check_eq("j3_idle", done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/draw_sched.md
DRAW_SCHED -- requirements
Module: draw_sched

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL have port start, input, 1, draw request, held high by requester until done is seen.
REQ-004 SHALL have port done, output, 1, job complete.
REQ-005 SHALL have port clear_en, input, 1, fill screen black before drawing.
REQ-006 SHALL have ports colour (input, 3), centre_x (input, 8), centre_y (input, 7) and diameter (input, 8), holding the job parameters.
REQ-007 SHALL have ports r_colour (output, 3), r_centre_x (output, 8), r_centre_y (output, 7) and r_diameter (output, 8), holding the latched parameters for the Reuleaux engine.
REQ-008 SHALL have ports fill_start (output, 1) and fill_done (input, 1), forming the fillscreen engine handshake.
REQ-009 SHALL have ports fill_x (input, 8), fill_y (input, 7), fill_colour (input, 3) and fill_plot (input, 1), carrying the fillscreen engine pixel stream.
REQ-010 SHALL have ports reul_start (output, 1) and reul_done (input, 1), forming the Reuleaux engine handshake.
REQ-011 SHALL have ports reul_x (input, 8), reul_y (input, 7), reul_colour (input, 3) and reul_plot (input, 1), carrying the Reuleaux engine pixel stream.
REQ-012 SHALL have ports vga_x (output, 8), vga_y (output, 7), vga_colour (output, 3) and vga_plot (output, 1), driving the shared VGA adapter port.
REQ-013 SHALL have port busy_cycles, output, 16, cycle count of the last or current job, saturating.
REQ-014 SHALL have port clip_count, output, 16, count of suppressed off-screen plots in the current job, saturating.

Function
REQ-015 SHALL implement the Moore FSM states IDLE, FILL, FILL_ACK, DRAW, DRAW_ACK and DONE.
REQ-016 SHALL, in IDLE with start=1 at an edge, latch colour, centre_x, centre_y and diameter into r_*, clear busy_cycles and clip_count, and go to FILL if clear_en=1, otherwise DRAW.
REQ-017 SHALL hold fill_start=1 in FILL only and go to FILL_ACK on the first edge with fill_done=1.
REQ-018 SHALL hold fill_start=0 in FILL_ACK and go to DRAW on the first edge with fill_done=0.
REQ-019 SHALL hold reul_start=1 in DRAW only and go to DRAW_ACK on the first edge with reul_done=1.
REQ-020 SHALL hold reul_start=0 in DRAW_ACK and go to DONE on the first edge with reul_done=0.
REQ-021 SHALL assert done=1 only in DONE and return to IDLE on the first edge with start=0; start staying high holds DONE.
REQ-022 SHALL ignore start outside IDLE; a start pulse dropped mid-job does not abort the job.
REQ-023 SHALL ignore changes on colour, centre_x, centre_y and diameter outside IDLE; r_* hold their latched values until the next accepted start.
REQ-024 SHALL route the fill_* stream to vga_* in FILL and the reul_* stream in DRAW, combinationally with zero latency.
REQ-025 SHALL force vga_plot=0 in IDLE, FILL_ACK, DRAW_ACK and DONE; vga_x, vga_y and vga_colour are 0 in those states.
REQ-026 SHALL force vga_plot=0 and increment clip_count when the selected plot=1 and x>159 or y>119 (clipping window 160x120).
REQ-027 SHALL increment busy_cycles every cycle in states other than IDLE and DONE, saturating at 16'hFFFF.
REQ-028 SHALL saturate clip_count at 16'hFFFF.
REQ-029 SHALL hold busy_cycles and clip_count in IDLE and DONE until the next accepted start.
REQ-030 SHALL advance only one state per edge when an engine done is already high on entry; e.g. FILL to FILL_ACK occurs at the next edge, giving one cycle of fill_start=1.

Reset
REQ-031 SHALL, on rst=1 at an edge, go to IDLE and clear done, fill_start, reul_start, r_*, busy_cycles and clip_count to 0, which also clears vga_plot.
REQ-032 SHALL have rst override all other inputs, including mid-job; the engine starts drop the next cycle and no ACK wait occurs.

Verification
REQ-033 SHALL be verified with: clear_en=1, colour=3'b010, (80,60), d=40, start=1 -> fill_start high until fill_done, then reul_start; done=1; r_*=(2,80,60,40); start=0 -> IDLE next edge.
REQ-034 SHALL be verified with: clear_en=0, start=1 -> fill_start never asserts; reul_start=1 the cycle after the IDLE edge.
REQ-035 SHALL be verified with: reul stream x=190, y=50, plot=1 for 5 cycles -> vga_plot=0 throughout, clip_count=5.
REQ-036 SHALL be verified with: y=127, x=10, plot=1 -> vga_plot=0, clip_count incremented; a fill stream of x=159, y=119 -> vga_plot=1.
REQ-037 SHALL be verified with: rst=1 for one edge in DRAW -> next cycle reul_start=0, done=0, busy_cycles=0, state IDLE; a new start is accepted.
REQ-038 SHALL be verified with: centre_x changed to 60 during DRAW -> r_centre_x stays 80; a fill engine with 10-cycle done latency -> busy_cycles equals the cycles counted from FILL through DRAW_ACK.
